// File: rtl/vedic_12_seq.sv
// Sequential 12x12 unsigned multiplier: one 6x6 Vedic core reused over four
// steps, with valid/ready handshakes on the operand and result sides.

module vedic_6 (
    input  logic [5:0]  x_i,
    input  logic [5:0]  y_i,
    output logic [11:0] z_o
);
    logic [5:0] q0, q1, q2, q3;

    // Urdhva-tiryakbhyam split into 3-bit halves.
    assign q0 = {3'b0, x_i[2:0]} * {3'b0, y_i[2:0]};
    assign q1 = {3'b0, x_i[2:0]} * {3'b0, y_i[5:3]};
    assign q2 = {3'b0, x_i[5:3]} * {3'b0, y_i[2:0]};
    assign q3 = {3'b0, x_i[5:3]} * {3'b0, y_i[5:3]};

    assign z_o = {6'b0, q0} + ({6'b0, q1} << 3) + ({6'b0, q2} << 3) + ({6'b0, q3} << 6);
endmodule

module vedic_12_seq #(
    parameter int ZERO_BYPASS = 1,
    parameter int OUT_REG     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [11:0] a_q, a_d, b_q, b_d;
    logic [23:0] acc_q, acc_d;

    logic [5:0]  vx, vy;
    logic [11:0] pp;
    logic [3:0]  shift;
    logic [23:0] pp_ext;

    always_comb begin
        vx    = a_q[5:0];
        vy    = b_q[5:0];
        shift = 4'd0;
        case (step_q)
            2'd0: begin vx = a_q[5:0];  vy = b_q[5:0];  shift = 4'd0;  end
            2'd1: begin vx = a_q[5:0];  vy = b_q[11:6]; shift = 4'd6;  end
            2'd2: begin vx = a_q[11:6]; vy = b_q[5:0];  shift = 4'd6;  end
            default: begin vx = a_q[11:6]; vy = b_q[11:6]; shift = 4'd12; end
        endcase
    end

    vedic_6 u_core (
        .x_i (vx),
        .y_i (vy),
        .z_o (pp)
    );

    assign pp_ext = {12'b0, pp} << shift;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = '0;
                    step_d = '0;
                    if (ZERO_BYPASS != 0 && (a == '0 || b == '0))
                        state_d = DONE;
                    else
                        state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_ext;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3)
                    state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [23:0] p_q;
            // Loaded on the edge entering DONE so p stays put until the next result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    p_q <= '0;
                else if (state_d == DONE && state_q != DONE)
                    p_q <= acc_d;
            end
            assign p = p_q;
        end else begin : g_out_acc
            assign p = acc_q;
        end
    endgenerate

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_vedic_12_seq.sv
// Bench for vedic_12_seq: directed latency/handshake scenarios plus a random
// producer/consumer stream scored against plain a*b.

module tb_vedic_12_seq;
    logic        clk, rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [11:0] a, b;
    logic [23:0] p;
    logic        nz_in_valid, nz_in_ready, nz_out_valid, nz_out_ready, nz_busy;
    logic [11:0] nz_a, nz_b;
    logic [23:0] nz_p;

    int checks = 0;
    int errors = 0;

    vedic_12_seq #(.ZERO_BYPASS(1), .OUT_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    vedic_12_seq #(.ZERO_BYPASS(0), .OUT_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
        .a(nz_a), .b(nz_b), .out_valid(nz_out_valid), .out_ready(nz_out_ready),
        .p(nz_p), .busy(nz_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction; reports product, edges from accept to out_valid, and whether bounds held.
    task automatic run_txn(input bit sel, input logic [11:0] ta, input logic [11:0] tb_,
                           output logic [23:0] pr, output int lat, output bit ok);
        int w;
        ok = 1'b1;
        lat = -1;
        pr = '0;
        if (sel) begin nz_a = ta; nz_b = tb_; nz_in_valid = 1'b1; end
        else     begin a = ta;    b = tb_;    in_valid = 1'b1;    end
        w = 0;
        while (!(sel ? nz_in_ready : in_ready) && w < 50) begin step(); w++; end
        if (!(sel ? nz_in_ready : in_ready)) begin
            ok = 1'b0;
            nz_in_valid = 1'b0;
            in_valid = 1'b0;
            return;
        end
        step();
        nz_in_valid = 1'b0;
        in_valid = 1'b0;
        lat = 0;
        while (!(sel ? nz_out_valid : out_valid) && lat < 50) begin step(); lat++; end
        if (!(sel ? nz_out_valid : out_valid)) begin ok = 1'b0; return; end
        pr = sel ? nz_p : p;
        if (sel) nz_out_ready = 1'b1; else out_ready = 1'b1;
        step();
        nz_out_ready = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        nz_in_valid = 1'b0; nz_a = '0; nz_b = '0; nz_out_ready = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_main: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 000000",
                     in_ready, out_valid, busy, p);
        end
        checks++;
        if ({nz_in_ready, nz_out_valid, nz_busy, nz_p} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_nz: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 000000",
                     nz_in_ready, nz_out_valid, nz_busy, nz_p);
        end
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_max();
        logic [23:0] pr;
        int lat;
        bit ok;
        a = 12'hFFF; b = 12'hFFF; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({in_ready, busy, out_valid} !== 3'b010) begin
                errors++;
                $display("FAIL max_mul_cycle%0d: got rdy=%b busy=%b vld=%b want 0 1 0",
                         i, in_ready, busy, out_valid);
            end
            step();
        end
        checks++;
        if ({out_valid, in_ready, p} !== {1'b1, 1'b0, 24'hFFE001}) begin
            errors++;
            $display("FAIL max_done: got vld=%b rdy=%b p=%h want 1 0 ffe001", out_valid, in_ready, p);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy, p} !== {1'b0, 1'b1, 1'b0, 24'hFFE001}) begin
            errors++;
            $display("FAIL max_after_hs: got vld=%b rdy=%b busy=%b p=%h want 0 1 0 ffe001",
                     out_valid, in_ready, busy, p);
        end
        run_txn(1'b1, 12'hFFF, 12'hFFF, pr, lat, ok);
        checks++;
        if (!ok || pr !== 24'hFFE001 || lat != 4) begin
            errors++;
            $display("FAIL max_nz: got ok=%0d p=%h lat=%0d want 1 ffe001 4", ok, pr, lat);
        end
    endtask

    task automatic test_paths();
        logic [11:0] va [4] = '{12'd100, 12'h040, 12'h001, 12'h03F};
        logic [11:0] vb [4] = '{12'd200, 12'h001, 12'h040, 12'hFC0};
        logic [23:0] ve [4] = '{24'h004E20, 24'h000040, 24'h000040, 24'h00F81};
        logic [23:0] pr;
        int lat;
        bit ok;
        ve[3] = 24'(12'h03F) * 24'(12'hFC0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                run_txn(s[0], va[i], vb[i], pr, lat, ok);
                checks++;
                if (!ok || pr !== ve[i] || lat != 4) begin
                    errors++;
                    $display("FAIL path_%0d_dut%0d: got ok=%0d p=%h lat=%0d want 1 %h 4",
                             i, s, ok, pr, lat, ve[i]);
                end
            end
        end
    endtask

    task automatic test_zero_bypass();
        logic [23:0] pr;
        int lat;
        bit ok;
        run_txn(1'b0, 12'h000, 12'hABC, pr, lat, ok);
        checks++;
        if (!ok || pr !== 24'h0 || lat != 0) begin
            errors++;
            $display("FAIL zero_a_bypass: got ok=%0d p=%h lat=%0d want 1 000000 0", ok, pr, lat);
        end
        run_txn(1'b0, 12'h5A5, 12'h000, pr, lat, ok);
        checks++;
        if (!ok || pr !== 24'h0 || lat != 0) begin
            errors++;
            $display("FAIL zero_b_bypass: got ok=%0d p=%h lat=%0d want 1 000000 0", ok, pr, lat);
        end
        run_txn(1'b1, 12'h000, 12'hABC, pr, lat, ok);
        checks++;
        if (!ok || pr !== 24'h0 || lat != 4) begin
            errors++;
            $display("FAIL zero_no_bypass: got ok=%0d p=%h lat=%0d want 1 000000 4", ok, pr, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] exp_p;
        int w;
        exp_p = 24'(12'h123) * 24'(12'h456);
        a = 12'h123; b = 12'h456; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin step(); w++; end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 12'($urandom);
            b = 12'($urandom);
            checks++;
            if ({out_valid, in_ready, p} !== {1'b1, 1'b0, exp_p}) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b p=%h want 1 0 %h",
                         i, out_valid, in_ready, p, exp_p);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready, p} !== {1'b0, 1'b1, exp_p}) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b p=%h want 0 1 %h", out_valid, in_ready, p, exp_p);
        end
        repeat (3) step();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_single: got vld=%b busy=%b want 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [23:0] pr;
        int lat;
        bit ok;
        a = 12'h123; b = 12'h456; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, p} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL rst_async: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 000000",
                     in_ready, out_valid, busy, p);
        end
        #2 rst = 1'b0;
        step();
        run_txn(1'b0, 12'h123, 12'h456, pr, lat, ok);
        checks++;
        if (!ok || pr !== 24'h04EDC2 || lat != 4) begin
            errors++;
            $display("FAIL rst_next_txn: got ok=%0d p=%h lat=%0d want 1 04edc2 4", ok, pr, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        int sent, got, stray;
        bit timeout;
        sent = 0; got = 0; stray = 0; timeout = 1'b0;
        fork
            begin : producer
                logic [11:0] ta, tb_;
                int w;
                for (int k = 0; k < 200 && !timeout; k++) begin
                    repeat ($urandom_range(0, 3)) step();
                    ta = ($urandom_range(0, 9) == 0) ? 12'h0 : 12'($urandom);
                    tb_ = ($urandom_range(0, 9) == 0) ? 12'h0 : 12'($urandom);
                    a = ta; b = tb_; in_valid = 1'b1;
                    w = 0;
                    while (!in_ready && w < 500) begin step(); w++; end
                    if (!in_ready) begin
                        timeout = 1'b1;
                    end else begin
                        exp_q.push_back(24'(ta) * 24'(tb_));
                        sent++;
                        step();
                    end
                    in_valid = 1'b0;
                end
            end
            begin : consumer
                int cyc;
                logic [23:0] e;
                cyc = 0;
                while (got < 200 && cyc < 20000 && !timeout) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            stray++;
                        end else begin
                            e = exp_q.pop_front();
                            checks++;
                            if (p !== e) begin
                                errors++;
                                $display("FAIL b2b_result%0d: got %h want %h", got, p, e);
                            end
                        end
                        got++;
                    end
                    step();
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if (timeout || got != 200 || sent != 200 || stray != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d stray=%0d left=%0d timeout=%0d want 200 200 0 0 0",
                     sent, got, stray, exp_q.size(), timeout);
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_paths();
        test_zero_bypass();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
